// File: rtl/hdmi_tmds_encoder.sv
// hdmi_tmds_encoder: single-channel DVI/HDMI TMDS 8b/10b encoder, 2-clock latency
// Ports: clk    - pixel clock, all state on rising edge
//        resetn - asynchronous active-low reset
//        de     - data enable (1 = encode data, 0 = encode ctrl)
//        data   - 8-bit pixel component
//        ctrl   - control bits {c1,c0}
//        tmds   - 10-bit encoded symbol, bit 0 transmitted first
module hdmi_tmds_encoder (
    input  logic       clk,
    input  logic       resetn,
    input  logic       de,
    input  logic [7:0] data,
    input  logic [1:0] ctrl,
    output logic [9:0] tmds
);
    logic [3:0]        n1d;
    logic              use_xnor;
    logic [8:0]        qm_d;
    logic [8:0]        qm_q;
    logic              de_q;
    logic [1:0]        ctrl_q;
    logic [3:0]        n1;
    logic [3:0]        n0;
    logic signed [4:0] diff;
    logic signed [4:0] cnt_d;
    logic signed [4:0] cnt_q;
    logic [9:0]        tmds_d;
    logic [9:0]        tmds_q;
    logic              case_a;
    logic              case_b;

    assign n1d      = 4'($countones(data));
    assign use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !data[0]);

    // XNOR of two bits equals their XOR inverted, so one chain serves both modes
    always_comb begin
        qm_d[0] = data[0];
        for (int i = 1; i < 8; i++) qm_d[i] = qm_d[i-1] ^ data[i] ^ use_xnor;
        qm_d[8] = ~use_xnor;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            qm_q   <= '0;
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
        end else begin
            qm_q   <= qm_d;
            de_q   <= de;
            ctrl_q <= ctrl;
        end
    end

    assign n1     = 4'($countones(qm_q[7:0]));
    assign n0     = 4'd8 - n1;
    assign diff   = $signed({1'b0, n1}) - $signed({1'b0, n0});
    assign case_a = (cnt_q == 0) || (n1 == n0);
    assign case_b = (cnt_q > 0 && n1 > n0) || (cnt_q < 0 && n0 > n1);

    // cnt tracks the true running disparity of the emitted 10-bit symbols
    always_comb begin
        tmds_d = ctrl_q == 2'b00 ? 10'h354 : ctrl_q == 2'b01 ? 10'h0AB : ctrl_q == 2'b10 ? 10'h154 : 10'h2AB;
        cnt_d  = '0;
        if (de_q) begin
            if (case_a) begin
                tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                cnt_d  = qm_q[8] ? cnt_q + diff : cnt_q - diff;
            end else if (case_b) begin
                tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                cnt_d  = cnt_q - diff + $signed({3'b000, qm_q[8], 1'b0});
            end else begin
                tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
                cnt_d  = cnt_q + diff - $signed({3'b000, ~qm_q[8], 1'b0});
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmds_q <= 10'h354;
            cnt_q  <= '0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds = tmds_q;
endmodule

// File: tb/tb_hdmi_tmds_encoder.sv
// tb_hdmi_tmds_encoder: self-checking bench with a disparity-based reference model
module tb_hdmi_tmds_encoder;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       de = 1'b0;
    logic [7:0] data = 8'h00;
    logic [1:0] ctrl = 2'b00;
    logic [9:0] tmds;

    int nchk = 0;
    int nerr = 0;

    hdmi_tmds_encoder dut (
        .clk   (clk),
        .resetn(resetn),
        .de    (de),
        .data  (data),
        .ctrl  (ctrl),
        .tmds  (tmds)
    );

    always #5 clk = ~clk;

    logic [9:0] token [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    // Encode one pixel given the running disparity c (ones minus zeros sent so far)
    function automatic logic [9:0] enc(input logic [7:0] d, input int c);
        int ones = 0;
        int n1 = 0;
        int n0;
        bit xn;
        logic [8:0] q;
        logic [9:0] t;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        for (int i = 0; i < 8; i++) n1 += int'(q[i]);
        n0 = 8 - n1;
        if (c == 0 || n1 == n0) t = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
        else if ((c > 0 && n1 > n0) || (c < 0 && n0 > n1)) t = {1'b1, q[8], ~q[7:0]};
        else t = {1'b0, q[8], q[7:0]};
        return t;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] t);
        logic [7:0] x;
        logic [7:0] d;
        x = t[9] ? ~t[7:0] : t[7:0];
        d[0] = x[0];
        for (int i = 1; i < 8; i++) d[i] = t[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
        return d;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model state: the two-clock pipeline as plain variables
    logic       m_de = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [1:0] m_ctrl = 2'b00;
    logic [9:0] exp_t = 10'h354;
    int         exp_c = 0;
    logic       exp_de = 1'b0;
    logic [7:0] exp_d = 8'h00;

    // Hand-computed literal expectations travel through their own two-stage pipe
    bit lv_in = 0, lv_s = 0, lv_o = 0;
    int lt_in = 0, lt_s = 0, lt_o = 0;
    bit lcv_in = 0, lcv_s = 0, lcv_o = 0;
    int lc_in = 0, lc_s = 0, lc_o = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_de = 1'b0; m_data = 8'h00; m_ctrl = 2'b00;
            exp_t = 10'h354; exp_c = 0; exp_de = 1'b0; exp_d = 8'h00;
            lv_s = 0; lv_o = 0; lcv_s = 0; lcv_o = 0;
        end else begin
            if (m_de) begin
                exp_t = enc(m_data, exp_c);
                exp_c = exp_c + 2 * $countones(exp_t) - 10;
            end else begin
                exp_t = token[m_ctrl];
                exp_c = 0;
            end
            exp_de = m_de; exp_d = m_data;
            m_de = de; m_data = data; m_ctrl = ctrl;
            lv_o = lv_s; lt_o = lt_s; lcv_o = lcv_s; lc_o = lc_s;
            lv_s = lv_in; lt_s = lt_in; lcv_s = lcv_in; lc_s = lc_in;
        end
    end

    int run_d = 0;

    always @(negedge clk) begin
        check("tmds", int'(tmds), int'(exp_t));
        check("cnt", int'(dut.cnt_q), exp_c);
        if (resetn && exp_de) begin
            check("decode", int'(dec(tmds)), int'(exp_d));
            run_d += 2 * $countones(tmds) - 10;
            check("dc_bound", int'(run_d <= 10 && run_d >= -10), 1);
        end else begin
            run_d = 0;
        end
        if (lv_o) check("literal_tmds", int'(tmds), lt_o);
        if (lcv_o) check("literal_cnt", int'(dut.cnt_q), lc_o);
    end

    task automatic tick(input logic e, input logic [7:0] d, input logic [1:0] c,
                        input bit lv = 0, input int lt = 0, input bit lcv = 0, input int lc = 0);
        @(negedge clk);
        de = e; data = d; ctrl = c;
        lv_in = lv; lt_in = lt; lcv_in = lcv; lc_in = lc;
    endtask

    initial begin
        bit de_r = 1'b0;
        repeat (4) tick(1'($urandom), 8'($urandom), 2'($urandom));
        check("reset_tmds", int'(tmds), 'h354);
        tick(1'b0, 8'($urandom), 2'b01, 1, 'h0AB);
        resetn = 1'b1;
        tick(1'b0, 8'h00, 2'b01);
        check("release_hold", int'(tmds), 'h354);
        tick(1'b0, 8'h00, 2'b00, 1, 'h354, 1, 0);
        tick(1'b0, 8'h00, 2'b01, 1, 'h0AB);
        tick(1'b0, 8'h00, 2'b10, 1, 'h154);
        tick(1'b0, 8'h00, 2'b11, 1, 'h2AB);
        tick(1'b1, 8'h00, 2'b00, 1, 'h100, 1, -8);
        tick(1'b1, 8'h00, 2'b00, 1, 'h3FF, 1, 2);
        tick(1'b1, 8'h00, 2'b00, 1, 'h100, 1, -6);
        tick(1'b0, 8'h00, 2'b00, 1, 'h354, 1, 0);
        tick(1'b1, 8'hFF, 2'b00, 1, 'h200, 1, -8);
        tick(1'b0, 8'h00, 2'b10, 1, 'h154, 1, 0);
        tick(1'b1, 8'h00, 2'b00, 1, 'h100, 1, -8);
        tick(1'b0, 8'h00, 2'b11, 1, 'h2AB, 1, 0);
        tick(1'b1, 8'h00, 2'b00, 1, 'h100, 1, -8);
        tick(1'b0, 8'h00, 2'b00);
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(15) == 0) de_r = ~de_r;
            tick(de_r, 8'($urandom), 2'($urandom));
        end
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 check("async_reset_tmds", int'(tmds), 'h354);
        check("async_reset_cnt", int'(dut.cnt_q), 0);
        tick(1'b1, 8'h5A, 2'b00);
        resetn = 1'b1;
        repeat (4) tick(1'b1, 8'($urandom), 2'b00);
        tick(1'b0, 8'h00, 2'b00);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
